branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: Branch_resolve

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of cycles flush is held after a taken branch (legal range 1..15).
REQ-002 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have in_valid  input  1  a branch operand set is presented.
REQ-005 SHALL have in_ready  output  1  the block accepts the operand set this cycle.
REQ-006 SHALL have PC  input  32  address of the branch instruction.
REQ-007 SHALL have Sign_ext_b  input  32  sign-extended, pre-shifted B-type offset.
REQ-008 SHALL have funct3  input  3  branch type from Instruction_code[14:12].
REQ-009 SHALL have rs1_data, rs2_data  input  32 each  operands.
REQ-010 SHALL have out_valid  output  1  result registers hold a result.
REQ-011 SHALL have out_ready  input  1  the consumer takes the result.
REQ-012 SHALL have taken  output  1; next_pc  output  32; flush  output  1; illegal  output  1; misalign  output  1.

Function
REQ-013 SHALL accept the input on a cycle with in_valid && in_ready and present the result with out_valid=1 on the next cycle (latency 1).
REQ-014 SHALL evaluate funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
REQ-015 SHALL treat funct3 010/011 as illegal: illegal=1, taken=0, next_pc=PC+4.
REQ-016 SHALL compute target = PC + Sign_ext_b modulo 2^32 and fall-through = PC + 4 modulo 2^32, with no overflow flag.
REQ-017 SHALL drive next_pc = taken ? target : fall-through, registered with out_valid.
REQ-018 SHALL implement states IDLE, RESULT and FLUSH.
REQ-019 IDLE SHALL assert in_ready=1 and out_valid=0, and SHALL move to RESULT on acceptance.
REQ-020 RESULT SHALL assert out_valid=1 and hold every result output stable until out_ready=1.
REQ-021 RESULT SHALL assert in_ready = out_ready && !taken.
REQ-022 In RESULT with out_ready=1 and taken=1, the block SHALL move to FLUSH and load the counter with FLUSH_CYCLES.
REQ-023 In RESULT with out_ready=1, taken=0 and a simultaneous acceptance, the block SHALL stay in RESULT with the new result (back-to-back throughput, one per cycle).
REQ-024 In RESULT with out_ready=1, taken=0 and no acceptance, the block SHALL move to IDLE.
REQ-025 FLUSH SHALL assert flush=1, in_ready=1 and out_valid=0, and SHALL discard any in_valid input (wrong-path instruction).
REQ-026 FLUSH SHALL decrement the counter each cycle and return to IDLE when the counter equals 1, so that flush is high for exactly FLUSH_CYCLES cycles.
REQ-027 flush SHALL be 0 in IDLE and RESULT.

Reset
REQ-028 When reset=1 at a clock edge, the block SHALL enter IDLE, clear the counter, and drive out_valid, taken, flush, illegal and misalign to 0 and next_pc to 32'h0.
REQ-029 Reset SHALL take priority over every other event, including in mid-FLUSH: flush deasserts on the cycle after the reset edge and the pending result is dropped.

Configuration
REQ-030 With macro BRANCH_MISALIGN_CHECK_EN defined, a taken branch whose target has bit1=1 SHALL set misalign=1 and force taken=0 and next_pc=PC+4, and no FLUSH SHALL follow.
REQ-031 Without BRANCH_MISALIGN_CHECK_EN, the misalign port SHALL remain present and tied to 0, and the target SHALL be used unchecked.

Structure
REQ-032 Funct3 encoding constants, the state encoding, and the PC increment constant 4 SHALL live in shared package Branch_pkg.
REQ-033 The condition evaluation SHALL be a combinational sub-module Branch_compare (inputs funct3, rs1_data, rs2_data; outputs cond, illegal).
REQ-034 The state machine, counter and result registers SHALL reside in Branch_resolve.

Verification
REQ-035 SHALL cover: PC=0x100, Sign_ext_b=0xFFFFFFF0, funct3=000, rs1=rs2=5 -> next cycle taken=1, next_pc=0xF0, then flush=1 for exactly 2 cycles.
REQ-036 SHALL cover: funct3=100, rs1=0xFFFFFFFF, rs2=1 -> taken=1; funct3=110 with the same operands -> taken=0, next_pc=PC+4.
REQ-037 SHALL cover: out_ready held 0 for 3 cycles with a non-taken result -> out_valid and next_pc stable and in_ready=0 throughout; out_ready=1 with in_valid=1 -> the new result appears the next cycle.
REQ-038 SHALL cover: funct3=011 -> illegal=1, taken=0, no flush.
REQ-039 SHALL cover: reset asserted on the 1st FLUSH cycle -> the next cycle has flush=0, out_valid=0, and the state is IDLE.
REQ-040 SHALL cover, with BRANCH_MISALIGN_CHECK_EN defined: PC=0x200, Sign_ext_b=0x6, beq true -> misalign=1, taken=0, next_pc=0x204, no flush.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution block: funct3 encodings,
// FSM state encoding, PC increment and the registered result payload.
package branch_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;

    // B-type funct3 encodings (Instruction_code[14:12])
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESULT = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    typedef struct packed {
        logic            taken;
        logic            illegal;
        logic            misalign;
        logic [XLEN-1:0] next_pc;
    } br_result_t;

endpackage

// File: rtl/branch_compare.sv
// Combinational branch condition evaluation.
// Ports:
//   funct3   - branch type
//   rs1_data - first operand
//   rs2_data - second operand
//   cond     - branch condition is true (always 0 for illegal encodings)
//   illegal  - funct3 is not a defined branch type (010 / 011)
module branch_compare
    import branch_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            cond,
    output logic            illegal
);

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  cond = (rs1_data == rs2_data);
            F3_BNE:  cond = (rs1_data != rs2_data);
            F3_BLT:  cond = ($signed(rs1_data) <  $signed(rs2_data));
            F3_BGE:  cond = ($signed(rs1_data) >= $signed(rs2_data));
            F3_BLTU: cond = (rs1_data <  rs2_data);
            F3_BGEU: cond = (rs1_data >= rs2_data);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution stage: evaluates a conditional branch, registers the
// taken / next_pc result with a valid/ready handshake and holds flush for
// FLUSH_CYCLES cycles after a taken branch is consumed.
// Optional feature macro: BRANCH_MISALIGN_CHECK_EN -- a taken branch whose
// target has bit1 set is reported as misaligned and resolved as not taken.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_valid / in_ready   - operand set handshake
//   PC, Sign_ext_b        - branch address and pre-shifted offset
//   funct3                - branch type
//   rs1_data, rs2_data    - operands
//   out_valid / out_ready - result handshake
//   taken, next_pc        - resolved direction and next fetch address
//   flush                 - wrong-path kill, high for FLUSH_CYCLES cycles
//   illegal, misalign     - exception indications for the result
module branch_resolve
    import branch_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] Sign_ext_b,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic [XLEN-1:0] next_pc,
    output logic            flush,
    output logic            illegal,
    output logic            misalign
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    br_result_t        res_q, res_d;
    br_result_t        res_new;
    logic              cmp_cond;
    logic              cmp_illegal;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   fall_thru;
    logic              take;
    logic              mis;
    logic              load;

    branch_compare u_compare (
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .cond     (cmp_cond),
        .illegal  (cmp_illegal)
    );

    // Result for the operand set currently presented
    always_comb begin
        target    = PC + Sign_ext_b;
        fall_thru = PC + PC_INC;
        take      = cmp_cond && !cmp_illegal;
        mis       = 1'b0;
`ifdef BRANCH_MISALIGN_CHECK_EN
        if (take && target[1]) begin
            mis  = 1'b1;
            take = 1'b0;
        end
`endif
        res_new.taken    = take;
        res_new.illegal  = cmp_illegal;
        res_new.misalign = mis;
        res_new.next_pc  = take ? target : fall_thru;
    end

    // Next-state, counter and handshake logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        in_ready = 1'b0;
        load     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                // A taken result blocks new input: the next instruction is wrong-path
                in_ready = out_ready && !res_q.taken;
                if (out_ready) begin
                    if (res_q.taken) begin
                        state_d = ST_FLUSH;
                        cnt_d   = CNT_W'(FLUSH_CYCLES);
                    end else if (in_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                // Input is accepted and dropped while flushing
                in_ready = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            res_d = res_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign out_valid = (state_q == ST_RESULT);
    assign flush     = (state_q == ST_FLUSH);
    assign taken     = res_q.taken;
    assign next_pc   = res_q.next_pc;
    assign illegal   = res_q.illegal;
    assign misalign  = res_q.misalign;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboarded bench for branch_resolve: directed scenarios followed by
// random traffic, checked against a behavioural branch model.
module tb_branch_resolve;

    localparam int unsigned FC = 2;

    typedef struct packed {
        logic        taken;
        logic        illegal;
        logic        misalign;
        logic [31:0] next_pc;
    } res_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [31:0] off;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        out_valid;
    logic        out_ready;
    logic        taken;
    logic [31:0] next_pc;
    logic        flush;
    logic        illegal;
    logic        misalign;

    int n_cmp;
    int n_bad;

    res_t q[$];
    // Occupancy model: a pending result and the remaining flush cycles
    bit   pend;
    bit   pend_taken;
    int   flush_left;

    branch_resolve #(.FLUSH_CYCLES(FC)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .PC         (pc),
        .Sign_ext_b (off),
        .funct3     (f3),
        .rs1_data   (rs1),
        .rs2_data   (rs2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .taken      (taken),
        .next_pc    (next_pc),
        .flush      (flush),
        .illegal    (illegal),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic res_t ref_model(input logic [31:0] a_pc, input logic [31:0] a_off,
                                       input logic [2:0] a_f3, input logic [31:0] a,
                                       input logic [31:0] b);
        res_t        r;
        bit          c;
        logic [31:0] tgt;
        r = '0;
        c = 1'b0;
        case (a_f3)
            3'd0: c = (a == b);
            3'd1: c = (a != b);
            3'd4: c = ($signed(a) < $signed(b));
            3'd5: c = ($signed(a) >= $signed(b));
            3'd6: c = (a < b);
            3'd7: c = (a >= b);
            default: r.illegal = 1'b1;
        endcase
        tgt = a_pc + a_off;
`ifdef BRANCH_MISALIGN_CHECK_EN
        if (c && tgt[1]) begin
            r.misalign = 1'b1;
            c = 1'b0;
        end
`endif
        r.taken   = c;
        r.next_pc = c ? tgt : a_pc + 32'd4;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; checks handshake/flush against the model
    task automatic cycle(input bit iv, input logic [31:0] a_pc, input logic [31:0] a_off,
                         input logic [2:0] a_f3, input logic [31:0] a, input logic [31:0] b,
                         input bit ordy);
        res_t r;
        bit   exp_ready;
        in_valid  = iv;
        pc        = a_pc;
        off       = a_off;
        f3        = a_f3;
        rs1       = a;
        rs2       = b;
        out_ready = ordy;
        #1;
        if (flush_left > 0)  exp_ready = 1'b1;
        else if (pend)       exp_ready = ordy && !pend_taken;
        else                 exp_ready = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("flush", 32'(flush), 32'(flush_left > 0));
        chk("out_valid", 32'(out_valid), 32'(pend && flush_left == 0));
        if (flush_left > 0) begin
            flush_left--;
        end else if (pend) begin
            if (ordy) begin
                if (pend_taken) begin
                    pend       = 1'b0;
                    flush_left = FC;
                end else if (iv) begin
                    r = ref_model(a_pc, a_off, a_f3, a, b);
                    q.push_back(r);
                    pend_taken = r.taken;
                end else begin
                    pend = 1'b0;
                end
            end
        end else if (iv) begin
            r = ref_model(a_pc, a_off, a_f3, a, b);
            q.push_back(r);
            pend       = 1'b1;
            pend_taken = r.taken;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input bit ordy);
        cycle(1'b0, 32'h0, 32'h0, 3'd0, 32'h0, 32'h0, ordy);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        pend       = 1'b0;
        pend_taken = 1'b0;
        flush_left = 0;
        q.delete();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_taken", 32'(taken), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_next_pc", next_pc, 32'h0);
    endtask

    // Monitor: compare the presented result with the scoreboard head
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL result: out_valid with no expected result at %0t", $time);
            end else begin
                if ({taken, illegal, misalign, next_pc} !== q[0]) begin
                    n_bad++;
                    $display("FAIL result: got t=%b i=%b m=%b pc=%h expected t=%b i=%b m=%b pc=%h at %0t",
                             taken, illegal, misalign, next_pc,
                             q[0].taken, q[0].illegal, q[0].misalign, q[0].next_pc, $time);
                end
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] o;
        n_cmp = 0;
        n_bad = 0;
        pend = 1'b0;
        pend_taken = 1'b0;
        flush_left = 0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        pc = '0; off = '0; f3 = '0; rs1 = '0; rs2 = '0;
        reset = 1'b1;
        @(posedge clk);
        do_reset();

        // Taken beq with negative offset, then flush
        cycle(1'b1, 32'h100, 32'hFFFF_FFF0, 3'd0, 32'd5, 32'd5, 1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // Signed vs unsigned compare on the same operands
        cycle(1'b1, 32'h300, 32'h40, 3'd4, 32'hFFFF_FFFF, 32'd1, 1'b1);
        repeat (FC + 2) idle_cycle(1'b1);
        cycle(1'b1, 32'h300, 32'h40, 3'd6, 32'hFFFF_FFFF, 32'd1, 1'b1);
        idle_cycle(1'b1);

        // Stall a not-taken result, then back-to-back acceptance
        cycle(1'b1, 32'h400, 32'h80, 3'd1, 32'd7, 32'd7, 1'b0);
        repeat (3) cycle(1'b1, 32'h500, 32'h10, 3'd0, 32'd1, 32'd2, 1'b0);
        cycle(1'b1, 32'h600, 32'h20, 3'd7, 32'd1, 32'd2, 1'b1);
        idle_cycle(1'b1);

        // Illegal funct3
        cycle(1'b1, 32'h700, 32'h8, 3'd3, 32'd1, 32'd1, 1'b1);
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // Reset on the first flush cycle
        cycle(1'b1, 32'h100, 32'hFFFF_FFF0, 3'd0, 32'd5, 32'd5, 1'b1);
        idle_cycle(1'b1);
        chk("flush_before_rst", 32'(flush), 32'd1);
        do_reset();

        // Target with bit1 set
        cycle(1'b1, 32'h200, 32'h6, 3'd0, 32'd9, 32'd9, 1'b1);
        repeat (FC + 2) idle_cycle(1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            b = $urandom;
            a = ($urandom_range(0, 3) == 0) ? b : $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 3);
            o = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) o[1] = 1'b1;
            cycle(($urandom_range(0, 9) < 7), $urandom, o, 3'($urandom_range(0, 7)), a, b,
                  ($urandom_range(0, 9) < 7));
        end

        // Drain
        for (int i = 0; i < 20; i++) begin
            if (pend || flush_left > 0) idle_cycle(1'b1);
        end
        chk("drain_queue", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
